// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, redirect with in-flight drain.
// Define FETCH_CNT_EN to build the delivered-instruction counter on fetch_cnt_o.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] inst_o,
    output logic        valid_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC_AL = RESET_PC & ~32'h3;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_tgt;
    logic        r_pend;
    logic        r_valid;
    logic [31:0] r_pc_out;
    logic [31:0] r_pc4_out;
    logic [31:0] r_inst;

    logic        w_req;
    logic        w_ack;
    logic [31:0] w_redir_pc;

    assign w_redir_pc = redirect_pc_i & ~32'h3;

    // A request already on the bus stays up until acked; a new one needs a free or draining slot.
    always_comb begin
        w_req = 1'b0;
        if (!rst_i) begin
            if (r_state == DRAIN) begin
                w_req = 1'b1;
            end else begin
                w_req = r_pend || !r_valid || !stall_i;
            end
        end
    end

    assign w_ack       = w_req && imem_ack_i;
    assign imem_req_o  = w_req;
    assign imem_addr_o = r_pc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= FETCH;
            r_pc      <= RESET_PC_AL;
            r_tgt     <= 32'h0;
            r_pend    <= 1'b0;
            r_valid   <= 1'b0;
            r_pc_out  <= 32'h0;
            r_pc4_out <= 32'h0;
            r_inst    <= 32'h0;
        end else begin
            case (r_state)
                FETCH: begin
                    r_pend <= w_req && !w_ack;
                    if (redirect_i) begin
                        r_valid <= 1'b0;
                        if (w_req && !w_ack) begin
                            r_state <= DRAIN;
                            r_tgt   <= w_redir_pc;
                            r_pend  <= 1'b0;
                        end else begin
                            r_pc <= w_redir_pc;
                        end
                    end else if (w_ack) begin
                        r_valid   <= 1'b1;
                        r_pc_out  <= r_pc;
                        r_pc4_out <= r_pc + 32'd4;
                        r_inst    <= imem_rdata_i;
                        r_pc      <= r_pc + 32'd4;
                    end else if (r_valid && !stall_i) begin
                        r_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    r_valid <= 1'b0;
                    r_pend  <= 1'b0;
                    if (redirect_i) begin
                        r_tgt <= w_redir_pc;
                    end
                    // Stale response lands here and is dropped; the latest target wins.
                    if (w_ack) begin
                        r_state <= FETCH;
                        r_pc    <= redirect_i ? w_redir_pc : r_tgt;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
        end
    end

    assign pc_o    = r_pc_out;
    assign pc4_o   = r_pc4_out;
    assign inst_o  = r_inst;
    assign valid_o = r_valid;

`ifdef FETCH_CNT_EN
    logic [31:0] r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= 32'h0;
        end else if (r_valid && !stall_i && !redirect_i) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign fetch_cnt_o = r_cnt;
`else
    assign fetch_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit, plus reset-mid-request and counter sequences.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic        ack;
    logic [31:0] rdata;

    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic [31:0] pc0, pc1, pc4_0, pc4_1, inst0, inst1, cnt0, cnt1;
    logic        vld0, vld1;

    fetch_unit dut0 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redir),
        .redirect_pc_i(redir_pc), .imem_req_o(req0), .imem_addr_o(addr0),
        .imem_ack_i(ack), .imem_rdata_i(rdata), .pc_o(pc0), .pc4_o(pc4_0),
        .inst_o(inst0), .valid_o(vld0), .fetch_cnt_o(cnt0)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redir),
        .redirect_pc_i(redir_pc), .imem_req_o(req1), .imem_addr_o(addr1),
        .imem_ack_i(ack), .imem_rdata_i(rdata), .pc_o(pc1), .pc4_o(pc4_1),
        .inst_o(inst1), .valid_o(vld1), .fetch_cnt_o(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FETCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl[NV];

    int n_chk;
    int n_pass;
    logic [31:0] exp_cnt;

    function automatic logic [31:0] D(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                                input logic a, input logic [31:0] rd, input logic q,
                                input logic [31:0] ad, input logic v, input logic [31:0] p,
                                input logic [31:0] p4, input logic [31:0] in);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rp; t.ack = a; t.rdata = rd;
        t.req = q; t.addr = ad; t.valid = v; t.pc = p; t.pc4 = p4; t.inst = in;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; exp_cnt = 32'h0;
        rst = 1'b1; stall = 1'b0; redir = 1'b0; redir_pc = 32'h0; ack = 1'b0; rdata = 32'h0;

        //     stall redir rpc  ack rdata          req addr  vld pc     pc4    inst
        tbl[0]  = mk(0,0,32'h0,  1,D(32'h0),      1,32'h0,  0,32'h0,  32'h0,  32'h0);
        tbl[1]  = mk(0,0,32'h0,  1,D(32'h4),      1,32'h4,  1,32'h0,  32'h4,  D(32'h0));
        tbl[2]  = mk(0,0,32'h0,  1,D(32'h8),      1,32'h8,  1,32'h4,  32'h8,  D(32'h4));
        tbl[3]  = mk(1,0,32'h0,  1,D(32'hC),      0,32'hC,  1,32'h8,  32'hC,  D(32'h8));
        tbl[4]  = mk(1,0,32'h0,  1,D(32'hC),      0,32'hC,  1,32'h8,  32'hC,  D(32'h8));
        tbl[5]  = mk(1,0,32'h0,  1,D(32'hC),      0,32'hC,  1,32'h8,  32'hC,  D(32'h8));
        tbl[6]  = mk(0,0,32'h0,  1,D(32'hC),      1,32'hC,  1,32'h8,  32'hC,  D(32'h8));
        tbl[7]  = mk(0,0,32'h0,  0,32'h0,         1,32'h10, 1,32'hC,  32'h10, D(32'hC));
        tbl[8]  = mk(0,1,32'h103,0,32'h0,         1,32'h10, 0,32'hC,  32'h10, D(32'hC));
        tbl[9]  = mk(0,0,32'h0,  1,32'hDEAD_0010, 1,32'h10, 0,32'hC,  32'h10, D(32'hC));
        tbl[10] = mk(0,0,32'h0,  0,32'h0,         1,32'h100,0,32'hC,  32'h10, D(32'hC));
        tbl[11] = mk(0,0,32'h0,  0,32'h0,         1,32'h100,0,32'hC,  32'h10, D(32'hC));
        tbl[12] = mk(0,0,32'h0,  1,D(32'h100),    1,32'h100,0,32'hC,  32'h10, D(32'hC));
        tbl[13] = mk(0,1,32'h20, 1,D(32'h104),    1,32'h104,1,32'h100,32'h104,D(32'h100));
        tbl[14] = mk(0,1,32'h40, 1,32'hDEAD_0020, 1,32'h20, 0,32'h100,32'h104,D(32'h100));
        tbl[15] = mk(0,0,32'h0,  1,D(32'h40),     1,32'h40, 0,32'h100,32'h104,D(32'h100));
        tbl[16] = mk(0,0,32'h0,  0,32'h0,         1,32'h44, 1,32'h40, 32'h44, D(32'h40));
        tbl[17] = mk(1,0,32'h0,  0,32'h0,         1,32'h44, 0,32'h40, 32'h44, D(32'h40));
        tbl[18] = mk(1,0,32'h0,  1,D(32'h44),     1,32'h44, 0,32'h40, 32'h44, D(32'h40));
        tbl[19] = mk(1,0,32'h0,  1,D(32'h48),     0,32'h48, 1,32'h44, 32'h48, D(32'h44));
        tbl[20] = mk(0,0,32'h0,  0,32'h0,         1,32'h48, 1,32'h44, 32'h48, D(32'h44));
        tbl[21] = mk(0,1,32'h80, 0,32'h0,         1,32'h48, 0,32'h44, 32'h48, D(32'h44));
        tbl[22] = mk(0,1,32'h93, 0,32'h0,         1,32'h48, 0,32'h44, 32'h48, D(32'h44));
        tbl[23] = mk(0,0,32'h0,  1,32'hDEAD_0048, 1,32'h48, 0,32'h44, 32'h48, D(32'h44));
        tbl[24] = mk(0,0,32'h0,  1,D(32'h90),     1,32'h90, 0,32'h44, 32'h48, D(32'h44));
        tbl[25] = mk(0,0,32'h0,  0,32'h0,         1,32'h94, 1,32'h90, 32'h94, D(32'h90));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'h0, req0}, 32'h0);
        chk("rst_valid", {31'h0, vld0}, 32'h0);
        chk("rst_pc", pc0, 32'h0);
        chk("rst_pc4", pc4_0, 32'h0);
        chk("rst_inst", inst0, 32'h0);
        chk("rst_cnt", cnt0, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            stall = tbl[i].stall; redir = tbl[i].redir; redir_pc = tbl[i].rpc;
            ack = tbl[i].ack; rdata = tbl[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'h0, req0}, {31'h0, tbl[i].req});
            chk($sformatf("v%0d_addr", i), addr0, tbl[i].addr);
            chk($sformatf("v%0d_valid", i), {31'h0, vld0}, {31'h0, tbl[i].valid});
            chk($sformatf("v%0d_pc", i), pc0, tbl[i].pc);
            chk($sformatf("v%0d_pc4", i), pc4_0, tbl[i].pc4);
            chk($sformatf("v%0d_inst", i), inst0, tbl[i].inst);
            chk($sformatf("v%0d_cnt", i), cnt0, exp_cnt);
            if (i == 0) chk("wrap_addr0", addr1, 32'hFFFF_FFFC);
            if (i == 1) begin
                chk("wrap_addr1", addr1, 32'h0);
                chk("wrap_pc", pc1, 32'hFFFF_FFFC);
                chk("wrap_pc4", pc4_1, 32'h0);
            end
            if (CNT_EN && tbl[i].valid && !tbl[i].stall && !tbl[i].redir)
                exp_cnt = exp_cnt + 32'd1;
        end

        // Reset while a request is outstanding
        @(posedge clk);
        #1;
        stall = 1'b0; redir = 1'b0; ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_req", {31'h0, req0}, 32'h0);
        chk("midrst_valid", {31'h0, vld0}, 32'h0);
        chk("midrst_pc", pc0, 32'h0);
        chk("midrst_cnt", cnt0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; ack = 1'b1; rdata = D(32'h0);
        @(negedge clk);
        chk("postrst_req", {31'h0, req0}, 32'h1);
        chk("postrst_addr", addr0, 32'h0);

        // Counter: five deliveries, one consume, two stall cycles
        for (int k = 1; k < 5; k++) begin
            @(posedge clk);
            #1;
            rdata = D(32'(k * 4));
        end
        @(posedge clk);
        #1;
        ack = 1'b0;
        @(negedge clk);
        chk("cnt_valid5", {31'h0, vld0}, 32'h1);
        chk("cnt_pc5", pc0, 32'h10);
        chk("cnt_inst5", inst0, D(32'h10));
        @(posedge clk);
        #1;
        stall = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("cnt_valid_drop", {31'h0, vld0}, 32'h0);
        chk("cnt_final", cnt0, CNT_EN ? 32'd5 : 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have port clk_i  input  1  the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_i  input  1  the reset, asynchronous and active-high.
REQ-004 The block SHALL have port stall_i  input  1  downstream IF/ID register cannot accept; hold outputs.
REQ-005 The block SHALL have port redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-006 The block SHALL have port redirect_pc_i  input  32  redirect target address.
REQ-007 The block SHALL have port imem_req_o  output  1  instruction memory request.
REQ-008 The block SHALL have port imem_addr_o  output  32  request address, word aligned.
REQ-009 The block SHALL have port imem_ack_i  input  1  memory ack; imem_rdata_i valid this cycle.
REQ-010 The block SHALL have port imem_rdata_i  input  32  fetched instruction word.
REQ-011 The block SHALL have ports pc_o, pc4_o and inst_o, each output 32, holding the fetched PC, PC+4 and instruction that feed the IF/ID register's pc_i, pc4_i and inst_i.
REQ-012 The block SHALL have port valid_o  output  1  pc_o/pc4_o/inst_o hold a live instruction.
REQ-013 The block SHALL have port fetch_cnt_o  output  32  delivered-instruction count (see Configuration).

Function
REQ-014 The block SHALL implement states FETCH (issue or hold request) and DRAIN (discard the in-flight response after a redirect).
REQ-015 The block SHALL hold at most one request outstanding, and SHALL keep imem_req_o high with imem_addr_o stable from issue until the cycle imem_ack_i=1.
REQ-016 In FETCH, the block SHALL start a new request only when the output slot is free or being consumed this cycle: valid_o=0 or stall_i=0.
REQ-017 Acks SHALL be accepted in the same cycle as the request (zero wait state), giving 1 instruction/cycle throughput with stall_i=0.
REQ-018 On an ack in FETCH with no redirect, the block SHALL at the next edge load inst_o=imem_rdata_i, pc_o=imem_addr_o, pc4_o=imem_addr_o+4 and valid_o=1, and SHALL advance the internal pc to pc+4.
REQ-019 Address arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 SHALL wrap to 32'h0000_0000.
REQ-020 While valid_o=1 and stall_i=1, pc_o, pc4_o, inst_o and valid_o SHALL hold unchanged.
REQ-021 When valid_o=1, stall_i=0 and no new data arrives, valid_o SHALL drop to 0 at the next edge.
REQ-022 redirect_i SHALL take priority over stall_i and ack: at the next edge valid_o=0 and pc=redirect_pc_i with bits [1:0] forced to 0.
REQ-023 If a redirect occurs while a request is outstanding and not acked, the block SHALL enter DRAIN, keep the old request asserted until ack, discard that data, then return to FETCH and request the redirect pc the cycle after that ack.
REQ-024 If a redirect coincides with an ack, the block SHALL discard the data and request the redirect target in the next cycle.
REQ-025 A redirect in DRAIN SHALL overwrite the pending target; the last redirect SHALL win.

Reset
REQ-026 While rst_i=1, the block SHALL hold pc_o, pc4_o, inst_o and fetch_cnt_o at 0, with valid_o=0, imem_req_o=0, internal pc=RESET_PC and state=FETCH.
REQ-027 In the first cycle after rst_i falls, the block SHALL raise imem_req_o with imem_addr_o=RESET_PC.
REQ-028 Reset asserted mid-request SHALL abandon the request immediately, with no DRAIN on exit.

Configuration
REQ-029 With macro FETCH_CNT_EN defined, fetch_cnt_o SHALL increment by 1 each cycle valid_o=1 and stall_i=0 and redirect_i=0, wrapping from 32'hFFFF_FFFF to 0.
REQ-030 Without FETCH_CNT_EN, the block SHALL tie fetch_cnt_o to 0 and include no counter logic.

Verification
REQ-031 Release reset with ack tied 1 and stall 0 -> addresses 0,4,8,12 on consecutive cycles; valid_o=1 from cycle 2, with pc4_o=pc_o+4.
REQ-032 Apply stall_i=1 for 3 cycles with valid_o=1 and pc_o=8 -> outputs frozen and imem_req_o=0; the pc=12 request issues on the cycle stall falls.
REQ-033 Apply redirect_pc_i=32'h0000_0103 with 2-wait-state memory and a request to 0x10 outstanding -> DRAIN holds the 0x10 request until ack, its data never reaches valid_o, and the next request is to 0x100.
REQ-034 Assert redirect together with ack to 0x20, target 0x40 -> valid_o=0 next cycle, then a request to 0x40.
REQ-035 Start from RESET_PC=32'hFFFF_FFFC -> second request to 0x0 and pc4_o=0 for the first instruction.
REQ-036 Build with FETCH_CNT_EN, deliver 5 instructions and stall 2 cycles -> fetch_cnt_o=5; without the macro -> fetch_cnt_o=0 throughout.
